// File: rtl/m92_pkg.sv
// -----------------------------------------------------------------------------
// m92_pkg
// Shared types and constants for the M92 SDRAM-side blocks.
//   sdr_rsp_state_t : state encoding of the main-CPU SDRAM responder FSM
//   SDR_LINE_WORDS  : number of 16-bit words in one backend burst / line buffer
//   sdrMergeBytes   : byte-enable merge of a 16-bit write into a stored word
// -----------------------------------------------------------------------------
package m92_pkg;

    localparam int SDR_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HIT      = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        WR_ISSUE = 3'd4,
        RESP     = 3'd5
    } sdr_rsp_state_t;

    // Replace only the bytes whose enable is set; be[1] selects the high byte.
    function automatic logic [15:0] sdrMergeBytes(input logic [15:0] oldWord,
                                                  input logic [15:0] newWord,
                                                  input logic [1:0]  be);
        logic [15:0] merged;
        merged[15:8] = be[1] ? newWord[15:8] : oldWord[15:8];
        merged[7:0]  = be[0] ? newWord[7:0]  : oldWord[7:0];
        return merged;
    endfunction

endpackage

// File: rtl/sdr_line_buffer.sv
// -----------------------------------------------------------------------------
// sdr_line_buffer
// Single 4x16 line buffer holding the most recent backend burst for the
// main-CPU SDRAM responder.
//   i_clk / i_rst      : clock, asynchronous active-high reset (clears valid)
//   i_fill, i_fillTag,
//   i_fillData         : load a whole 64-bit line and mark it valid with a tag
//   i_wr, i_wrIdx,
//   i_wrBe, i_wrData   : byte-merge one word (write-through update)
//   i_rdIdx, o_rdData  : combinational word read
//   o_valid, o_tag     : line state used by the owner for hit detection
// -----------------------------------------------------------------------------
module sdr_line_buffer
    import m92_pkg::*;
#(
    parameter int TAG_W = 22
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fill,
    input  logic [TAG_W-1:0] i_fillTag,
    input  logic [63:0]      i_fillData,
    input  logic             i_wr,
    input  logic [1:0]       i_wrIdx,
    input  logic [1:0]       i_wrBe,
    input  logic [15:0]      i_wrData,
    input  logic [1:0]       i_rdIdx,
    output logic [15:0]      o_rdData,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic [SDR_LINE_WORDS-1:0][15:0] r_words;
    logic                            r_valid;
    logic [TAG_W-1:0]                r_tag;

    // A fill replaces the whole line; a merge only ever touches the word
    // being written, so the two never need to happen in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_words <= '0;
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_fill) begin
            r_words <= i_fillData;
            r_valid <= 1'b1;
            r_tag   <= i_fillTag;
        end else if (i_wr) begin
            r_words[i_wrIdx] <= sdrMergeBytes(r_words[i_wrIdx], i_wrData, i_wrBe);
        end
    end

    assign o_rdData = r_words[i_rdIdx];
    assign o_valid  = r_valid;
    assign o_tag    = r_tag;

endmodule

// File: rtl/m92_sdr_cpu_responder.sv
// -----------------------------------------------------------------------------
// m92_sdr_cpu_responder
// SDRAM-side responder for the main-CPU sdr_cpu_* channel (CLK_96M domain).
// Turns a one-cycle request into a backend burst read or word write, returns a
// one-cycle ready pulse, and keeps one 4-word line so sequential reads hit.
//   CLK_96M, reset          : clock, asynchronous active-high reset
//   sdr_cpu_req/addr/wr_sel/din : request strobe, byte address, byte enables
//                             (00 = read), write data
//   sdr_cpu_dout, sdr_cpu_rdy : read word (held until next read), done pulse
//   mem_addr/rd/wr/be/din   : backend request side
//   mem_ack, mem_dout, mem_dvalid : backend response side
//   protocol_err            : sticky, request seen while busy
// -----------------------------------------------------------------------------
module m92_sdr_cpu_responder
    import m92_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter bit LINE_EN = 1'b1
) (
    input  logic              CLK_96M,
    input  logic              reset,
    input  logic              sdr_cpu_req,
    input  logic [ADDR_W-1:0] sdr_cpu_addr,
    input  logic [1:0]        sdr_cpu_wr_sel,
    input  logic [15:0]       sdr_cpu_din,
    output logic [15:0]       sdr_cpu_dout,
    output logic              sdr_cpu_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    input  logic [63:0]       mem_dout,
    input  logic              mem_dvalid,
    output logic              protocol_err
);

    localparam int TAG_W = ADDR_W - 3;

    sdr_rsp_state_t    r_state;
    logic [ADDR_W-1:1] r_addr;
    logic [1:0]        r_wrSel;
    logic [15:0]       r_din;
    logic [15:0]       r_dout;
    logic              r_protoErr;

    logic [TAG_W-1:0]                w_reqTag;
    logic [TAG_W-1:0]                w_curTag;
    logic [1:0]                      w_idx;
    logic                            w_bufValid;
    logic [TAG_W-1:0]                w_bufTag;
    logic [15:0]                     w_bufWord;
    logic                            w_reqHit;
    logic                            w_fill;
    logic                            w_wrMerge;
    logic [SDR_LINE_WORDS-1:0][15:0] w_burstWords;
    logic [15:0]                     w_burstWord;
    logic                            w_unusedAddrLsb;

    // Byte address bit 0 carries no information for a 16-bit port.
    assign w_unusedAddrLsb = sdr_cpu_addr[0];

    assign w_reqTag     = sdr_cpu_addr[ADDR_W-1:3];
    assign w_curTag     = r_addr[ADDR_W-1:3];
    assign w_idx        = r_addr[2:1];
    assign w_burstWords = mem_dout;
    assign w_burstWord  = w_burstWords[w_idx];

    // Hit is decided against the incoming address while still in IDLE.
    assign w_reqHit = LINE_EN && w_bufValid && (w_bufTag == w_reqTag);

    // Data may come together with the ack, so the fill covers both states.
    assign w_fill = mem_dvalid &&
                    ((r_state == RD_WAIT) || ((r_state == RD_ISSUE) && mem_ack));

    // Write-through: keep the buffered copy coherent when the write is accepted.
    assign w_wrMerge = LINE_EN && (r_state == WR_ISSUE) && mem_ack &&
                       w_bufValid && (w_bufTag == w_curTag);

    sdr_line_buffer #(
        .TAG_W(TAG_W)
    ) u_lineBuffer (
        .i_clk      (CLK_96M),
        .i_rst      (reset),
        .i_fill     (w_fill),
        .i_fillTag  (w_curTag),
        .i_fillData (mem_dout),
        .i_wr       (w_wrMerge),
        .i_wrIdx    (w_idx),
        .i_wrBe     (r_wrSel),
        .i_wrData   (r_din),
        .i_rdIdx    (w_idx),
        .o_rdData   (w_bufWord),
        .o_valid    (w_bufValid),
        .o_tag      (w_bufTag)
    );

    // Responder FSM. Requests arriving outside IDLE are dropped and only
    // flag the sticky protocol error; the transaction in flight is untouched.
    always_ff @(posedge CLK_96M or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wrSel    <= '0;
            r_din      <= '0;
            r_dout     <= '0;
            r_protoErr <= 1'b0;
        end else begin
            if (sdr_cpu_req && (r_state != IDLE)) begin
                r_protoErr <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (sdr_cpu_req) begin
                        r_addr  <= sdr_cpu_addr[ADDR_W-1:1];
                        r_wrSel <= sdr_cpu_wr_sel;
                        r_din   <= sdr_cpu_din;
                        if (sdr_cpu_wr_sel != 2'b00) begin
                            r_state <= WR_ISSUE;
                        end else if (w_reqHit) begin
                            r_state <= HIT;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                HIT: begin
                    r_dout  <= w_bufWord;
                    r_state <= RESP;
                end
                RD_ISSUE: begin
                    if (mem_ack) begin
                        if (mem_dvalid) begin
                            r_dout  <= w_burstWord;
                            r_state <= RESP;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_dvalid) begin
                        r_dout  <= w_burstWord;
                        r_state <= RESP;
                    end
                end
                WR_ISSUE: begin
                    if (mem_ack) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Backend request fields are only non-zero while the matching request
    // is being presented, so the port is quiet in every other state.
    always_comb begin
        mem_addr = '0;
        mem_be   = 2'b00;
        mem_din  = 16'h0000;
        if (r_state == RD_ISSUE) begin
            mem_addr = {w_curTag, 3'b000};
        end else if (r_state == WR_ISSUE) begin
            mem_addr = {r_addr, 1'b0};
            mem_be   = r_wrSel;
            mem_din  = r_din;
        end
    end

    assign mem_rd       = (r_state == RD_ISSUE);
    assign mem_wr       = (r_state == WR_ISSUE);
    assign sdr_cpu_rdy  = (r_state == RESP);
    assign sdr_cpu_dout = r_dout;
    assign protocol_err = r_protoErr;

endmodule

// File: tb/tb_m92_sdr_cpu_responder.sv
// -----------------------------------------------------------------------------
// tb_m92_sdr_cpu_responder
// Bench for the main-CPU SDRAM responder. Instance 0 has the line buffer
// enabled, instance 1 has it disabled. A behavioural SDRAM backend answers
// both with programmable ack / data delays and a word-addressed memory.
// -----------------------------------------------------------------------------
module tb_m92_sdr_cpu_responder;

    typedef struct {
        logic [24:0] addr;
        logic [1:0]  sel;
        logic [15:0] din;
        int          ackD;
        int          dvD;
        logic [15:0] expDout;
        int          expLat;
        int          expBursts;
        bit          chkMem;
        logic [24:0] expMemAddr;
        logic [1:0]  expBe;
        logic [15:0] expMemDin;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    logic        req       [2];
    logic [24:0] addr      [2];
    logic [1:0]  sel       [2];
    logic [15:0] din       [2];
    logic [15:0] dout      [2];
    logic        rdy       [2];
    logic [24:0] memAddr   [2];
    logic        memRd     [2];
    logic        memWr     [2];
    logic [1:0]  memBe     [2];
    logic [15:0] memDin    [2];
    logic        memAck    [2];
    logic [63:0] memDout   [2];
    logic        memDvalid [2];
    logic        protoErr  [2];

    // Backend bookkeeping, written only by the backend process.
    bit          bBusy    [2];
    bit          bIsRd    [2];
    int          bCnt     [2];
    logic [24:0] lastAddr [2];
    logic [1:0]  lastBe   [2];
    logic [15:0] lastDin  [2];
    int          burstCnt [2];
    int          wrCnt    [2];
    int          rdyCnt   [2];
    int          bothCnt;

    // Backend timing, written only by the stimulus process.
    int ackDly [2];
    int dvDly  [2];

    logic [15:0] memArr [int];
    logic [15:0] refMem [int];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m92_sdr_cpu_responder #(.ADDR_W(25), .LINE_EN(1'b1)) u_dut0 (
        .CLK_96M        (clk),
        .reset          (reset),
        .sdr_cpu_req    (req[0]),
        .sdr_cpu_addr   (addr[0]),
        .sdr_cpu_wr_sel (sel[0]),
        .sdr_cpu_din    (din[0]),
        .sdr_cpu_dout   (dout[0]),
        .sdr_cpu_rdy    (rdy[0]),
        .mem_addr       (memAddr[0]),
        .mem_rd         (memRd[0]),
        .mem_wr         (memWr[0]),
        .mem_be         (memBe[0]),
        .mem_din        (memDin[0]),
        .mem_ack        (memAck[0]),
        .mem_dout       (memDout[0]),
        .mem_dvalid     (memDvalid[0]),
        .protocol_err   (protoErr[0])
    );

    m92_sdr_cpu_responder #(.ADDR_W(25), .LINE_EN(1'b0)) u_dut1 (
        .CLK_96M        (clk),
        .reset          (reset),
        .sdr_cpu_req    (req[1]),
        .sdr_cpu_addr   (addr[1]),
        .sdr_cpu_wr_sel (sel[1]),
        .sdr_cpu_din    (din[1]),
        .sdr_cpu_dout   (dout[1]),
        .sdr_cpu_rdy    (rdy[1]),
        .mem_addr       (memAddr[1]),
        .mem_rd         (memRd[1]),
        .mem_wr         (memWr[1]),
        .mem_be         (memBe[1]),
        .mem_din        (memDin[1]),
        .mem_ack        (memAck[1]),
        .mem_dout       (memDout[1]),
        .mem_dvalid     (memDvalid[1]),
        .protocol_err   (protoErr[1])
    );

    // Power-up memory contents: line 0x100 holds 1111/2222/3333/4444,
    // everything else a hashed pattern of the word address.
    function automatic logic [15:0] initWord(input int wa);
        if (wa >= 32'h80 && wa <= 32'h83) begin
            return 16'((wa - 32'h7F) * 32'h1111);
        end
        return 16'((wa * 40503) ^ 23130);
    endfunction

    function automatic logic [15:0] memRead(input int wa);
        return memArr.exists(wa) ? memArr[wa] : initWord(wa);
    endfunction

    function automatic logic [15:0] refRead(input int wa);
        return refMem.exists(wa) ? refMem[wa] : initWord(wa);
    endfunction

    // Behavioural SDRAM backend plus ready / overlap monitors. Responses are
    // driven on the falling edge; a request seen first at a falling edge is
    // counted as cycle 1 of the backend access.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            memAck[d]    = 1'b0;
            memDvalid[d] = 1'b0;
            if (reset) begin
                bBusy[d] = 1'b0;
            end else begin
                if (!bBusy[d] && (memRd[d] || memWr[d])) begin
                    bBusy[d]    = 1'b1;
                    bCnt[d]     = 0;
                    bIsRd[d]    = memRd[d];
                    lastAddr[d] = memAddr[d];
                    lastBe[d]   = memBe[d];
                    lastDin[d]  = memDin[d];
                    if (memRd[d]) burstCnt[d]++;
                    else          wrCnt[d]++;
                end
                if (bBusy[d]) begin
                    bCnt[d]++;
                    if (bCnt[d] == ackDly[d]) begin
                        memAck[d] = 1'b1;
                        if (!bIsRd[d]) begin
                            logic [15:0] w;
                            int          wa;
                            wa = int'(lastAddr[d] >> 1);
                            w  = memRead(wa);
                            if (lastBe[d][0]) w[7:0]  = lastDin[d][7:0];
                            if (lastBe[d][1]) w[15:8] = lastDin[d][15:8];
                            memArr[wa] = w;
                            bBusy[d]   = 1'b0;
                        end
                    end
                    if (bIsRd[d] && bCnt[d] == dvDly[d]) begin
                        int base;
                        base = int'(lastAddr[d] >> 1);
                        for (int n = 0; n < 4; n++) begin
                            memDout[d][16*n +: 16] = memRead(base + n);
                        end
                        memDvalid[d] = 1'b1;
                        bBusy[d]     = 1'b0;
                    end
                end
            end
            if (rdy[d]) rdyCnt[d]++;
            if (memRd[d] && memWr[d]) bothCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // One request; lat is the number of cycles from the request cycle to the
    // ready cycle (-1 if ready never came). Returns one cycle after ready.
    task automatic runTxn(input int d, input logic [24:0] a, input logic [1:0] s,
                          input logic [15:0] di, output int lat, output logic [15:0] q);
        @(negedge clk);
        #1;
        req[d]  = 1'b1;
        addr[d] = a;
        sel[d]  = s;
        din[d]  = di;
        @(negedge clk);
        #1;
        req[d] = 1'b0;
        lat    = 1;
        while (!rdy[d] && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!rdy[d]) lat = -1;
        q = dout[d];
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int d, input vec_t v, input string tag);
        int          b0;
        int          w0;
        int          r0;
        int          lat;
        logic [15:0] q;
        b0 = burstCnt[d];
        w0 = wrCnt[d];
        r0 = rdyCnt[d];
        ackDly[d] = v.ackD;
        dvDly[d]  = v.dvD;
        runTxn(d, v.addr, v.sel, v.din, lat, q);
        checkOutput({tag, ".latency"}, lat, v.expLat);
        checkOutput({tag, ".dout"}, q, v.expDout);
        checkOutput({tag, ".bursts"}, burstCnt[d] - b0, v.expBursts);
        checkOutput({tag, ".writes"}, wrCnt[d] - w0, (v.sel != 2'b00) ? 1 : 0);
        checkOutput({tag, ".rdyPulses"}, rdyCnt[d] - r0, 1);
        if (v.chkMem) begin
            checkOutput({tag, ".memAddr"}, lastAddr[d], v.expMemAddr);
            checkOutput({tag, ".memBe"}, lastBe[d], v.expBe);
            checkOutput({tag, ".memDin"}, lastDin[d], v.expMemDin);
        end
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl [9];
        vec_t        rv;
        int          lat;
        int          b0;
        int          r0;
        logic [15:0] q;
        bit          mValid;
        logic [21:0] mTag;
        logic [15:0] mLastDout;

        // Directed vectors for the buffered instance, applied right after reset.
        tbl[0] = '{25'h104, 2'b00, 16'h0000, 2, 5, 16'h3333, 6, 1, 1'b1, 25'h100, 2'b00, 16'h0000};
        tbl[1] = '{25'h106, 2'b00, 16'h0000, 1, 1, 16'h4444, 2, 0, 1'b0, 25'h000, 2'b00, 16'h0000};
        tbl[2] = '{25'h102, 2'b10, 16'hAB00, 1, 1, 16'h4444, 2, 0, 1'b1, 25'h102, 2'b10, 16'hAB00};
        tbl[3] = '{25'h102, 2'b00, 16'h0000, 1, 1, 16'hAB22, 2, 0, 1'b0, 25'h000, 2'b00, 16'h0000};
        tbl[4] = '{25'h103, 2'b00, 16'h0000, 1, 1, 16'hAB22, 2, 0, 1'b0, 25'h000, 2'b00, 16'h0000};
        tbl[5] = '{25'h100, 2'b01, 16'h12CD, 3, 3, 16'hAB22, 4, 0, 1'b1, 25'h100, 2'b01, 16'h12CD};
        tbl[6] = '{25'h100, 2'b00, 16'h0000, 1, 1, 16'h11CD, 2, 0, 1'b0, 25'h000, 2'b00, 16'h0000};
        tbl[7] = '{25'h208, 2'b00, 16'h0000, 2, 2, initWord(32'h104), 3, 1, 1'b1, 25'h208, 2'b00, 16'h0000};
        tbl[8] = '{25'h101, 2'b00, 16'h0000, 1, 1, 16'h11CD, 2, 1, 1'b1, 25'h100, 2'b00, 16'h0000};

        bothCnt = 0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; addr[d] = '0; sel[d] = 2'b00; din[d] = 16'h0;
            bBusy[d] = 1'b0; bIsRd[d] = 1'b0; bCnt[d] = 0;
            lastAddr[d] = '0; lastBe[d] = '0; lastDin[d] = '0;
            burstCnt[d] = 0; wrCnt[d] = 0; rdyCnt[d] = 0;
            ackDly[d] = 1; dvDly[d] = 2;
        end

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.dout", dout[0], 16'h0);
        checkOutput("reset.rdy", rdy[0], 1'b0);
        checkOutput("reset.memRd", memRd[0], 1'b0);
        checkOutput("reset.memWr", memWr[0], 1'b0);
        checkOutput("reset.memAddr", memAddr[0], 25'h0);
        checkOutput("reset.protoErr", protoErr[0], 1'b0);
        #1 reset = 1'b0;

        // Unbuffered instance: every read is a burst.
        $display("[TB] line buffer disabled, repeated read");
        for (int k = 0; k < 2; k++) begin
            tbl[0].addr = 25'h104;
            rv = '{25'h100, 2'b00, 16'h0000, 1, 2, 16'h1111, 3, 1, 1'b1, 25'h100, 2'b00, 16'h0000};
            applyStimulus(1, rv, $sformatf("noLine%0d", k));
        end

        // Reset in RD_WAIT abandons the read without a ready pulse.
        $display("[TB] reset during read wait");
        ackDly[0] = 1;
        dvDly[0]  = 8;
        r0 = rdyCnt[0];
        @(negedge clk);
        #1 req[0] = 1'b1; addr[0] = 25'h100; sel[0] = 2'b00;
        @(negedge clk);
        #1 req[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checkOutput("abandon.rdyPulses", rdyCnt[0] - r0, 0);
        checkOutput("abandon.protoErr", protoErr[0], 1'b0);
        checkOutput("abandon.dout", dout[0], 16'h0);
        rv = '{25'h100, 2'b00, 16'h0000, 1, 2, 16'h1111, 3, 1, 1'b1, 25'h100, 2'b00, 16'h0000};
        applyStimulus(0, rv, "afterReset");

        // Directed table on a freshly reset buffer.
        applyReset();
        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, tbl[i], $sformatf("vec%0d", i));
        end

        // Second request while the first is still issuing.
        $display("[TB] request while busy");
        checkOutput("busy.protoErrBefore", protoErr[0], 1'b0);
        ackDly[0] = 4;
        dvDly[0]  = 6;
        r0 = rdyCnt[0];
        b0 = burstCnt[0];
        @(negedge clk);
        #1 req[0] = 1'b1; addr[0] = 25'h3000; sel[0] = 2'b00;
        @(negedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        #1 req[0] = 1'b1; addr[0] = 25'h3010; sel[0] = 2'b01;
        @(negedge clk);
        #1 req[0] = 1'b0;
        lat = 0;
        while (!rdy[0] && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput("busy.rdySeen", rdy[0], 1'b1);
        checkOutput("busy.dout", dout[0], initWord(32'h1800));
        repeat (10) @(negedge clk);
        #1;
        checkOutput("busy.rdyPulses", rdyCnt[0] - r0, 1);
        checkOutput("busy.bursts", burstCnt[0] - b0, 1);
        checkOutput("busy.memAddr", lastAddr[0], 25'h3000);
        checkOutput("busy.protoErr", protoErr[0], 1'b1);

        applyReset();
        #1;
        checkOutput("busy.protoErrCleared", protoErr[0], 1'b0);

        // Randomized traffic over four lines against a line-level model.
        $display("[TB] randomized traffic");
        mValid    = 1'b0;
        mTag      = '0;
        mLastDout = 16'h0;
        for (int i = 0; i < 40; i++) begin
            logic [24:0] a;
            logic [15:0] mask;
            int          wa;
            bit          hit;
            a = 25'h8000 + 25'($urandom_range(0, 3) * 8) + 25'($urandom_range(0, 3) * 2)
                + 25'($urandom_range(0, 1));
            rv.addr = a;
            rv.sel  = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            rv.din  = 16'($urandom);
            rv.ackD = $urandom_range(1, 3);
            rv.dvD  = rv.ackD + $urandom_range(0, 3);
            wa      = int'(a >> 1);
            rv.chkMem = 1'b1;
            if (rv.sel == 2'b00) begin
                hit = mValid && (mTag == a[24:3]);
                rv.expLat     = hit ? 2 : rv.dvD + 1;
                rv.expBursts  = hit ? 0 : 1;
                rv.expDout    = refRead(wa);
                rv.chkMem     = !hit;
                rv.expMemAddr = {a[24:3], 3'b000};
                rv.expBe      = 2'b00;
                rv.expMemDin  = 16'h0;
                if (!hit) begin
                    mValid = 1'b1;
                    mTag   = a[24:3];
                end
                mLastDout = rv.expDout;
            end else begin
                rv.expLat     = rv.ackD + 1;
                rv.expBursts  = 0;
                rv.expDout    = mLastDout;
                rv.expMemAddr = {a[24:1], 1'b0};
                rv.expBe      = rv.sel;
                rv.expMemDin  = rv.din;
                mask = (rv.sel[1] ? 16'hFF00 : 16'h0000) | (rv.sel[0] ? 16'h00FF : 16'h0000);
                refMem[wa] = (refRead(wa) & ~mask) | (rv.din & mask);
            end
            applyStimulus(0, rv, $sformatf("rand%0d", i));
        end

        checkOutput("memRdWrOverlap", bothCnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
